mem_ctrl: RTL

Byte-serial memory controller downstream of the load/store buffer and instruction fetch unit. It owns the single 8-bit synchronous RAM/IO port. It arbitrates between a data request from the load/store buffer and a word fetch from the fetch unit, and sequences 1/2/4 multi-byte transfers, little-endian. It also returns sign- or zero-extended load data.

---
 rtl/mem_ctrl_pkg.sv | 59 +++++
 rtl/mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the byte-serial memory controller.
//   state_e          controller FSM states
//   src_e            which client owns the in-flight transfer
//   SIZE_*           lsb_size encodings (byte / half / word)
//   IO_BASE_DEFAULT  default IO window base (addr[17:16] == 2'b11)
//   is_io()          IO window decode
//   last_idx()       index of the final byte of a transfer for a given size
//   extend()         sign/zero extension of assembled load data
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_LSB = 1'b0,
    SRC_IF  = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // The IO window is selected by address bits [17:16] alone.
  localparam logic [31:0] IO_MASK = 32'h0003_0000;

  function automatic logic is_io(input logic [31:0] addr, input logic [31:0] base);
    return (addr & IO_MASK) == (base & IO_MASK);
  endfunction

  // Byte counter value of the last byte: 1, 2 or 4 bytes. Size 3 is
  // treated as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      SIZE_BYTE: r = 2'd0;
      SIZE_HALF: r = 2'd1;
      default:   r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data,
                                         input logic [1:0]  size,
                                         input logic        uns);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {{24{~uns & data[7]}}, data[7:0]};
      SIZE_HALF: r = {{16{~uns & data[15]}}, data[15:0]};
      default:   r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller for the single 8-bit synchronous RAM/IO
// port. Arbitrates between the load/store buffer (priority) and the fetch
// unit, and sequences 1/2/4-byte little-endian transfers.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes the controller
//   flush               misprediction flush (aborts reads, drops new fetch)
//   mem_din             RAM read byte for the address of the previous cycle
//   mem_dout/mem_a/mem_wr  RAM write byte, byte address, write strobe
//   io_buffer_full      IO FIFO full; stalls writes into the IO window
//   lsb_*               load/store request, ready, done pulse, load data
//   if_*                fetch request level, done pulse, instruction word
//   dbg_state           current FSM state, for observation
//
// Handshake: lsb_valid is a one-cycle pulse and is accepted only in a cycle
// where lsb_ready is high; if_req is a level held by the fetch unit until it
// sees if_done. Each accepted request produces exactly one done pulse on its
// own client unless a flush aborts it (reads only). All outputs are registered.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        lsb_valid,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_size,
  input  logic        lsb_unsigned,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ready,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  output state_e      dbg_state
);

  state_e      state, state_d;
  src_e        src, src_d;
  logic [1:0]  req_size, size_d;
  logic        req_uns, uns_d;
  logic [31:0] wdata, wdata_d;
  logic [1:0]  cnt, cnt_d;         // byte index being captured / written
  logic        rd_dv, rd_dv_d;     // mem_din carries a byte of this read
  logic [7:0]  hold, hold_d;       // read byte parked across a rdy stall
  logic        hold_vld, hold_vld_d;
  logic [31:0] rd_buf, rd_buf_d;

  logic [31:0] mem_a_d, lsb_rdata_d, if_data_d;
  logic [7:0]  mem_dout_d;
  logic        mem_wr_d, lsb_ready_d, lsb_done_d, if_done_d;

  logic [7:0]  rd_byte;
  logic [31:0] merged;
  logic [1:0]  last;

  assign dbg_state = state;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] r;
    case (i)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state;
    src_d       = src;
    size_d      = req_size;
    uns_d       = req_uns;
    wdata_d     = wdata;
    cnt_d       = cnt;
    rd_dv_d     = rd_dv;
    hold_d      = hold;
    hold_vld_d  = hold_vld;
    rd_buf_d    = rd_buf;
    mem_a_d     = mem_a;
    mem_dout_d  = mem_dout;
    mem_wr_d    = mem_wr;
    lsb_ready_d = lsb_ready;
    lsb_done_d  = lsb_done;
    lsb_rdata_d = lsb_rdata;
    if_done_d   = if_done;
    if_data_d   = if_data;

    last = last_idx(req_size);

    // The RAM keeps clocking while rdy is low, so the byte on mem_din at
    // the first frozen edge would be lost; it is parked in hold and used
    // in place of mem_din at the edge that resumes the read.
    rd_byte = hold_vld ? hold : mem_din;

    merged = rd_buf;
    case (cnt)
      2'd0:    merged[7:0]   = rd_byte;
      2'd1:    merged[15:8]  = rd_byte;
      2'd2:    merged[23:16] = rd_byte;
      default: merged[31:24] = rd_byte;
    endcase

    if (!rdy) begin
      mem_wr_d = 1'b0;
      if (state == ST_READ && rd_dv && !hold_vld) begin
        hold_d     = mem_din;
        hold_vld_d = 1'b1;
      end
    end else begin
      lsb_done_d = 1'b0;
      if_done_d  = 1'b0;
      hold_vld_d = 1'b0;

      case (state)
        ST_IDLE: begin
          if (lsb_valid) begin
            src_d       = SRC_LSB;
            size_d      = lsb_size;
            uns_d       = lsb_unsigned;
            wdata_d     = lsb_wdata;
            cnt_d       = 2'd0;
            rd_dv_d     = 1'b0;
            rd_buf_d    = '0;
            mem_a_d     = lsb_addr;
            lsb_ready_d = 1'b0;
            if (lsb_we) begin
              state_d    = ST_WRITE;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = !(is_io(lsb_addr, IO_BASE) && io_buffer_full);
            end else begin
              state_d = ST_READ;
            end
          // While if_done is high the fetch unit has not yet dropped the
          // request it just got answered, so that level is not a new fetch.
          end else if (if_req && !flush && !if_done) begin
            src_d       = SRC_IF;
            size_d      = SIZE_WORD;
            uns_d       = 1'b1;
            cnt_d       = 2'd0;
            rd_dv_d     = 1'b0;
            rd_buf_d    = '0;
            mem_a_d     = if_addr;
            lsb_ready_d = 1'b0;
            state_d     = ST_READ;
          end
        end

        ST_READ: begin
          if (flush) begin
            state_d     = ST_IDLE;
            lsb_ready_d = 1'b1;
            rd_dv_d     = 1'b0;
          end else if (!rd_dv) begin
            // First edge after acceptance: byte 0 arrives next cycle.
            rd_dv_d = 1'b1;
            if (last != 2'd0) mem_a_d = mem_a + 32'd1;
          end else begin
            rd_buf_d = merged;
            if (cnt == last) begin
              state_d     = ST_IDLE;
              lsb_ready_d = 1'b1;
              rd_dv_d     = 1'b0;
              if (src == SRC_LSB) begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = extend(merged, req_size, req_uns);
              end else begin
                if_done_d = 1'b1;
                if_data_d = merged;
              end
            end else begin
              cnt_d = cnt + 2'd1;
              // The address runs one byte ahead of the capture index and
              // stops at the last byte.
              if ((cnt + 2'd1) != last) mem_a_d = mem_a + 32'd1;
            end
          end
        end

        ST_WRITE: begin
          // mem_wr high means the current byte was written this cycle.
          if (mem_wr) begin
            if (cnt == last) begin
              state_d     = ST_IDLE;
              mem_wr_d    = 1'b0;
              lsb_done_d  = 1'b1;
              lsb_ready_d = 1'b1;
            end else begin
              cnt_d      = cnt + 2'd1;
              mem_a_d    = mem_a + 32'd1;
              mem_dout_d = byte_of(wdata, cnt + 2'd1);
              mem_wr_d   = !(is_io(mem_a + 32'd1, IO_BASE) && io_buffer_full);
            end
          end else begin
            // Stalled by the IO FIFO or by rdy: retry the same byte.
            mem_wr_d = !(is_io(mem_a, IO_BASE) && io_buffer_full);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      src       <= SRC_LSB;
      req_size  <= SIZE_BYTE;
      req_uns   <= 1'b0;
      wdata     <= '0;
      cnt       <= 2'd0;
      rd_dv     <= 1'b0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      rd_buf    <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
      lsb_ready <= 1'b1;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
    end else begin
      state     <= state_d;
      src       <= src_d;
      req_size  <= size_d;
      req_uns   <= uns_d;
      wdata     <= wdata_d;
      cnt       <= cnt_d;
      rd_dv     <= rd_dv_d;
      hold      <= hold_d;
      hold_vld  <= hold_vld_d;
      rd_buf    <= rd_buf_d;
      mem_a     <= mem_a_d;
      mem_dout  <= mem_dout_d;
      mem_wr    <= mem_wr_d;
      lsb_ready <= lsb_ready_d;
      lsb_done  <= lsb_done_d;
      lsb_rdata <= lsb_rdata_d;
      if_done   <= if_done_d;
      if_data   <= if_data_d;
    end
  end

  // A data request while busy would be silently dropped.
  a_lsb_req_when_busy: assert property (
    @(posedge clk) disable iff (rst) (rdy && lsb_valid) |-> lsb_ready
  );

endmodule
